// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory request/response channel.
// master is the fetch unit, slave is the instruction memory.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: RV32 fetch stage, PC, in-order fetch queue, redirect flush.
// Optional macro FETCH_MISALIGN_CHECK_EN enables misaligned-redirect fault mode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master imem,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    input  logic         id_ready,
    output logic         if_id_valid,
    output logic [31:0]  if_id_pc,
    output logic [31:0]  if_id_pc_p4,
    output logic [31:0]  if_id_instruction,
    output logic         fetch_fault
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 2;

    typedef logic [PW:0] ptr_t;
    typedef enum logic { RUN, FAULT } mode_t;

    mode_t       mode;
    logic [31:0] pc;
    ptr_t        wr_ptr;
    ptr_t        fill_ptr;
    ptr_t        rd_ptr;
    ptr_t        drop_cnt;
    logic [31:0] pc_mem  [FIFO_DEPTH];
    logic [31:0] ins_mem [FIFO_DEPTH];

    ptr_t          alloc_cnt;
    ptr_t          unfilled_cnt;
    logic [CW-1:0] used_cnt;
    logic          credit;
    logic          req_fire;
    logic          rsp_drop;
    logic          rsp_fill;
    logic          pop;
    logic          misaligned;
    logic [31:0]   pc_load;

    // Stale responses still in flight consume credit just like live entries.
    assign alloc_cnt    = wr_ptr - rd_ptr;
    assign unfilled_cnt = wr_ptr - fill_ptr;
    assign used_cnt     = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
    assign credit       = used_cnt < CW'(FIFO_DEPTH);

    assign imem.imem_req_valid = credit && !redirect_valid
                               && (mode == RUN) && !rst;
    assign imem.imem_req_addr  = pc;

    assign req_fire = imem.imem_req_valid && imem.imem_req_ready;
    assign rsp_drop = imem.imem_rsp_valid && (drop_cnt != '0);
    assign rsp_fill = imem.imem_rsp_valid && (drop_cnt == '0);

    // Entries between rd and fill are returned; head is valid when any exist.
    assign if_id_valid       = fill_ptr != rd_ptr;
    assign if_id_pc          = pc_mem[rd_ptr[PW-1:0]];
    assign if_id_pc_p4       = if_id_pc + 32'd4;
    assign if_id_instruction = ins_mem[rd_ptr[PW-1:0]];

    assign pop = if_id_valid && id_ready && !redirect_valid;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misaligned  = redirect_pc[1:0] != 2'b00;
    assign pc_load     = redirect_pc;
    assign fetch_fault = mode == FAULT;
`else
    assign misaligned  = 1'b0;
    assign pc_load     = redirect_pc & 32'hFFFF_FFFC;
    assign fetch_fault = 1'b0;
`endif

    // Mode FSM: a misaligned redirect parks fetch until an aligned one.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode <= RUN;
        end else if (redirect_valid) begin
            mode <= misaligned ? FAULT : RUN;
        end
    end

    // Program counter: redirect target wins over sequential advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= pc_load;
        end else if (req_fire) begin
            pc <= pc + 32'd4;
        end
    end

    // Queue pointers: a redirect empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
        end else if (redirect_valid) begin
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
        end else begin
            wr_ptr   <= wr_ptr + ptr_t'(req_fire);
            fill_ptr <= fill_ptr + ptr_t'(rsp_fill);
            rd_ptr   <= rd_ptr + ptr_t'(pop);
        end
    end

    // Drop counter: unfilled entries become stale on flush; a response
    // arriving in the flush cycle is either stale already or one of them.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            drop_cnt <= drop_cnt + unfilled_cnt
                      - ptr_t'(imem.imem_rsp_valid);
        end else if (rsp_drop) begin
            drop_cnt <= drop_cnt - ptr_t'(1);
        end
    end

    // Queue payload storage; contents are qualified by the pointers.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pc_mem[wr_ptr[PW-1:0]] <= pc;
        end
        if (rsp_fill) begin
            ins_mem[fill_ptr[PW-1:0]] <= imem.imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit with an epoch-based
// reference model of the fetched instruction stream and a latency memory.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_p4;
    logic [31:0] if_id_instruction;
    logic        fetch_fault;

    fetch_unit_if imem ();

    fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .imem              (imem),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .id_ready          (id_ready),
        .if_id_valid       (if_id_valid),
        .if_id_pc          (if_id_pc),
        .if_id_pc_p4       (if_id_pc_p4),
        .if_id_instruction (if_id_instruction),
        .fetch_fault       (fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int          ep;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] live_q[$];
    logic [31:0] req_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] p4_log[$];
    int          live_filled;
    int          epoch;
    int          cyc;
    logic [31:0] next_pc;
    bit          fault;
    bit          in_reset;
    int          checks;
    int          errors;

    int          ready_pct;
    int          idr_pct;
    int          redir_pct;
    int          lat_lo;
    int          lat_hi;
    bit          force_redir;
    logic [31:0] force_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic int stale_cnt();
        int n = 0;
        foreach (mq[i]) if (mq[i].ep != epoch) n++;
        return n;
    endfunction

    function automatic bit exp_req_valid();
        return !fault && !redirect_valid
            && (live_q.size() + stale_cnt() < DEPTH);
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$],
                                         input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Compare DUT outputs with the model mid-cycle and log handshakes.
    task automatic do_check();
        bit ev;
        bit fv;
        if (in_reset) begin
            chk("rst_req_valid", 32'(imem.imem_req_valid), 32'd0);
            chk("rst_if_id_valid", 32'(if_id_valid), 32'd0);
            chk("rst_fetch_fault", 32'(fetch_fault), 32'd0);
            return;
        end
        ev = exp_req_valid();
        chk("req_valid", 32'(imem.imem_req_valid), 32'(ev));
        if (ev) chk("req_addr", imem.imem_req_addr, next_pc);
        fv = live_filled > 0;
        chk("if_id_valid", 32'(if_id_valid), 32'(fv));
        if (fv) begin
            chk("if_id_pc", if_id_pc, live_q[0]);
            chk("if_id_pc_p4", if_id_pc_p4, live_q[0] + 32'd4);
            chk("if_id_instr", if_id_instruction, mem_word(live_q[0]));
        end
        chk("fetch_fault", 32'(fetch_fault), 32'(fault));
        if (imem.imem_req_valid && imem.imem_req_ready)
            req_log.push_back(imem.imem_req_addr);
        if (if_id_valid && id_ready && !redirect_valid) begin
            pop_log.push_back(if_id_pc);
            p4_log.push_back(if_id_pc_p4);
        end
    endtask

    // Advance the model and the memory on the clock edge.
    task automatic model_update();
        bit    ev;
        bit    fire;
        bit    pop;
        int    due;
        mreq_t h;
        mreq_t r;
        cyc++;
        if (in_reset) return;
        ev   = exp_req_valid();
        fire = ev && imem.imem_req_ready;
        pop  = (live_filled > 0) && id_ready && !redirect_valid;
        if (imem.imem_rsp_valid && mq.size() > 0) begin
            h = mq.pop_front();
            if (h.ep == epoch) live_filled++;
        end
        if (pop) begin
            void'(live_q.pop_front());
            live_filled--;
        end
        if (fire) begin
            due = cyc + $urandom_range(lat_hi, lat_lo);
            if (mq.size() > 0 && due <= mq[$].due) due = mq[$].due + 1;
            r.pc  = next_pc;
            r.ep  = epoch;
            r.due = due;
            mq.push_back(r);
            live_q.push_back(next_pc);
            next_pc = next_pc + 32'd4;
        end
        if (redirect_valid) begin
            epoch++;
            live_q.delete();
            live_filled = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault   = redirect_pc[1:0] != 2'b00;
            next_pc = redirect_pc;
`else
            next_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
        end
    endtask

    // Drive inputs for the next cycle just after the edge.
    task automatic drive();
        logic [31:0] t;
        imem.imem_req_ready = $urandom_range(99) < ready_pct;
        id_ready            = $urandom_range(99) < idr_pct;
        if (!in_reset && mq.size() > 0 && mq[0].due <= cyc + 1) begin
            imem.imem_rsp_valid = 1'b1;
            imem.imem_rsp_data  = mem_word(mq[0].pc);
        end else begin
            imem.imem_rsp_valid = 1'b0;
            imem.imem_rsp_data  = $urandom;
        end
        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_pc;
            force_redir    = 1'b0;
        end else if (!in_reset && $urandom_range(99) < redir_pct) begin
            t = $urandom & 32'h0000_FFFC;
            if ($urandom_range(99) < 20) t = 32'hFFFF_FFF0 | (t & 32'hC);
            if ($urandom_range(99) < 10) t = t | 32'($urandom_range(3, 1));
            redirect_valid = 1'b1;
            redirect_pc    = t;
        end
    endtask

    task automatic step();
        @(negedge clk);
        do_check();
        @(posedge clk);
        model_update();
        #1;
        drive();
    endtask

    task automatic redirect_to(input logic [31:0] a);
        force_redir = 1'b1;
        force_pc    = a;
        step();
    endtask

    int wi;

    initial begin
        rst                 = 1'b1;
        in_reset            = 1'b1;
        checks              = 0;
        errors              = 0;
        cyc                 = 0;
        epoch               = 0;
        live_filled         = 0;
        fault               = 1'b0;
        next_pc             = RST_PC;
        ready_pct           = 100;
        idr_pct             = 100;
        redir_pct           = 0;
        lat_lo              = 1;
        lat_hi              = 1;
        force_redir         = 1'b0;
        force_pc            = '0;
        redirect_valid      = 1'b0;
        redirect_pc         = '0;
        id_ready            = 1'b1;
        imem.imem_req_ready = 1'b1;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = '0;

        repeat (3) step();
        rst      = 1'b0;
        in_reset = 1'b0;

        // Streaming from reset, latency 1.
        repeat (10) step();
        chk("stream_req0", qget(req_log, 0), 32'h0000_0100);
        chk("stream_req1", qget(req_log, 1), 32'h0000_0104);
        chk("stream_req2", qget(req_log, 2), 32'h0000_0108);
        chk("stream_pop0", qget(pop_log, 0), 32'h0000_0100);
        chk("stream_p4_0", qget(p4_log, 0), 32'h0000_0104);

        // Hazard stall: queue fills to depth and issue stops.
        idr_pct = 0;
        repeat (10) step();
        #1;
        chk("stall_blocked", 32'(imem.imem_req_valid), 32'd0);
        chk("stall_head", 32'(if_id_valid), 32'd1);
        idr_pct = 100;
        repeat (10) step();

        // Redirect with several fetches in flight at latency 3.
        lat_lo = 3;
        lat_hi = 3;
        repeat (8) step();
        redirect_to(32'h0000_2000);
        pop_log.delete();
        repeat (15) step();
        chk("redir_first_pc", qget(pop_log, 0), 32'h0000_2000);

        // PC wrap, then redirect coincident with a response and a pop.
        lat_lo = 1;
        lat_hi = 1;
        repeat (6) step();
        req_log.delete();
        pop_log.delete();
        p4_log.delete();
        redirect_to(32'hFFFF_FFF8);
        repeat (8) step();
        wi = -1;
        foreach (req_log[i]) if (req_log[i] == 32'hFFFF_FFFC) wi = i;
        chk("wrap_next_req", qget(req_log, wi + 1), 32'h0000_0000);
        wi = -1;
        foreach (pop_log[i]) if (pop_log[i] == 32'hFFFF_FFFC) wi = i;
        chk("wrap_pc_p4", qget(p4_log, wi), 32'h0000_0000);
        redirect_to(32'h0000_0500);
        step();
        #1;
        chk("flush_empty", 32'(if_id_valid), 32'd0);
        chk("flush_req_valid", 32'(imem.imem_req_valid), 32'd1);
        chk("flush_req_addr", imem.imem_req_addr, 32'h0000_0500);

        // Misaligned redirect.
        repeat (4) step();
        req_log.delete();
        redirect_to(32'h0000_3002);
        step();
        #1;
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_fault", 32'(fetch_fault), 32'd1);
        chk("mis_no_req", 32'(imem.imem_req_valid), 32'd0);
        repeat (3) step();
        chk("mis_req_count", 32'(req_log.size()), 32'd0);
        redirect_to(32'h0000_3000);
        step();
        #1;
        chk("mis_cleared", 32'(fetch_fault), 32'd0);
        chk("mis_resume_valid", 32'(imem.imem_req_valid), 32'd1);
        chk("mis_resume_addr", imem.imem_req_addr, 32'h0000_3000);
`else
        chk("mis_fault", 32'(fetch_fault), 32'd0);
        chk("mis_req_valid", 32'(imem.imem_req_valid), 32'd1);
        chk("mis_req_addr", imem.imem_req_addr, 32'h0000_3000);
`endif

        // Randomized traffic.
        ready_pct = 70;
        idr_pct   = 70;
        redir_pct = 3;
        lat_lo    = 1;
        lat_hi    = 4;
        repeat (4000) step();

        // Drain.
        ready_pct = 100;
        idr_pct   = 100;
        redir_pct = 0;
        redirect_to(32'h0000_4000);
        repeat (30) step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the pipelined RV32 core. Drives the program counter, issues in-order word fetches to instruction memory over a valid/ready request channel, and buffers returned instructions with their PC in a small in-order queue. It presents them to the IF-ID register as `if_id_valid` / `if_id_pc` / `if_id_pc_p4` / `if_id_instruction`, with `id_ready` as backpressure. On a branch/jump redirect it flushes queued and in-flight fetches and restarts at the new target.

## Interface
- `RESET_PC`, 32'h0000_0000: PC fetched first after reset.
- `FIFO_DEPTH`, 4: fetch queue entries; a power of 2 and ≥2.
- `clk` in, 1: single clock. All state updates on the rising edge.
- `rst` in, 1: reset, synchronous, active-high.
- `imem_req_valid` out, 1: fetch request valid.
- `imem_req_ready` in, 1: memory accepts request.
- `imem_req_addr` out, 32: word-aligned fetch address, equal to the current PC.
- `imem_rsp_valid` in, 1: response valid. Responses return in order, one per accepted request, with no backpressure.
- `imem_rsp_data` in, 32: instruction word.
- `redirect_valid` in, 1: taken branch/jump from EX; flush and restart.
- `redirect_pc` in, 32: redirect target.
- `id_ready` in, 1: ID accepts the head instruction. Low means hazard stall.
- `if_id_valid` out, 1: head entry holds a returned instruction.
- `if_id_pc` out, 32: PC of the head entry.
- `if_id_pc_p4` out, 32: `if_id_pc` + 4, mod 2^32.
- `if_id_instruction` out, 32: instruction word of the head entry.
- `fetch_fault` out, 1: misaligned redirect target (see Configuration).

## Operation
- **State:**
  - `pc` register.
  - Queue of `FIFO_DEPTH` entries {pc, instr, filled}, with three pointers: alloc (wr), fill, and rd.
  - `drop_cnt`, counting stale in-flight responses.
  - Mode FSM with states RUN and FAULT.
- **Credit rule:** `credit = (entries allocated + drop_cnt) < FIFO_DEPTH`.
- **Request signals:**
  - `imem_req_valid = credit && !redirect_valid && mode==RUN`.
  - `imem_req_addr = pc`.
- **Request handshake:** valid && ready allocates the entry at the alloc pointer with pc=`pc`, filled=0. Then `pc <= pc + 4`, wrapping mod 2^32.
- **Response handling:**
  - If `drop_cnt != 0`: the response is discarded and `drop_cnt` decrements.
  - Otherwise: the entry at the fill pointer gets instr=`imem_rsp_data`, filled=1, and the fill pointer advances.
  - A response with no outstanding request is a protocol violation and has undefined behaviour.
- **Output:**
  - `if_id_valid` = head entry allocated and filled.
  - The `if_id_*` fields are driven directly from the head entry.
  - Pop on `if_id_valid && id_ready`.
- **Redirect** (`redirect_valid`=1):
  - All queue entries are invalidated.
  - `drop_cnt <= drop_cnt + (allocated-but-unfilled entries) − (1 if a response arrives this cycle)`.
  - `pc <= redirect_pc`.
  - No request is issued this cycle.
  - Any pop in the same cycle is ignored by ID; the flush wins.
- **Simultaneous events:** allocate, fill, and pop in the same cycle are all legal and independent.
- **Queue bounds:**
  - Credit prevents overflow, so the queue never holds more than `FIFO_DEPTH` entries.
  - An empty or unfilled head gives `if_id_valid`=0.
- **FSM transitions:**
  - RUN→FAULT on a misaligned redirect (when the check is enabled).
  - FAULT→RUN on the next aligned redirect.
  - While in FAULT, responses are still drained via `drop_cnt`.

## Timing
- **Reset state** (`rst` sampled high):
  - pc=`RESET_PC`, queue empty, `drop_cnt`=0, mode=RUN.
  - Outputs: `imem_req_valid`=0, `if_id_valid`=0, `fetch_fault`=0.
  - `if_id_pc` and `if_id_instruction` are don't-care while invalid.
- **Reset mid-operation:** outstanding responses are the memory's responsibility; the memory is reset on the same `rst`.
- **First request:** `imem_req_valid` may rise the first cycle after `rst` deasserts.
- **Latency:** request accepted at cycle T with response at T+L (L≥1) gives `if_id_valid` at T+L+1.
- **Redirect latency:** redirect at cycle N gives the first request to the target at N+1.
- **Throughput:** one instruction per cycle sustained when `FIFO_DEPTH ≥ L+2` and `id_ready`=1. Smaller depths throttle issue via credit.
- **Combinational paths:** `imem_req_valid` depends combinationally on `redirect_valid` only. All other outputs are register-driven.

## Configuration
- **Macro:** `FETCH_MISALIGN_CHECK_EN`.
- **Defined:**
  - A redirect with `redirect_pc[1:0] != 0` moves the FSM to FAULT.
  - `fetch_fault` goes to 1 the next cycle and stays held.
  - No requests are issued until an aligned redirect, which clears `fetch_fault` the next cycle.
  - The pc register is loaded with the target anyway.
- **Undefined:**
  - `redirect_pc[1:0]` is forced to 2'b00 on load.
  - The FSM stays in RUN.
  - `fetch_fault` is tied to 0; the port stays present.

## Test plan
- **Reset and streaming:** `RESET_PC`=0x100, L=1, `id_ready`=1. Requests go to 0x100, 0x104, 0x108 on consecutive cycles. `if_id_valid` stays high from cycle 3, with pc_p4 = pc+4.
- **Stall and backpressure:** `id_ready`=0 for 10 cycles. Allocations stop at 4 entries, with no overflow. On release, the instructions come out in order, with none lost or duplicated.
- **Redirect with in-flight fetches:** L=3, redirect to 0x2000 while 3 requests are outstanding. All 3 stale responses are dropped, and the first `if_id_pc` after the redirect is 0x2000.
- **Redirect coincident with a response and a pop:** the response is dropped, the queue is empty the next cycle, and the request to the target is issued the next cycle.
- **PC wrap:** `RESET_PC`=0xFFFF_FFFC. The next request address is 0x0000_0000, and `if_id_pc_p4`=0 for the first instruction.
- **Misaligned redirect to 0x3002:**
  - Macro defined: `fetch_fault`=1 and no requests are issued; a later redirect to 0x3000 clears the fault and resumes fetch.
  - Macro undefined: the fetch goes to 0x3000.
